// File: rtl/pulp_clock_gate_ctrl.sv
// pulp_clock_gate_ctrl: idle-timeout sleep sequencer for N gated clock domains.
// Each domain goes through RUN -> DRAIN (sleep request) -> GATED -> WAKE -> RUN.
// In DRAIN it waits for the domain's acknowledge. In WAKE the clock runs for
// WAKE_CYCLES cycles before ready is reasserted.
// Optional feature macro: PULP_CG_CTRL_STATS_EN. When it is defined, the block
// keeps per-domain 32-bit saturating gated-cycle counters. When it is not
// defined, gated_cnt_o is tied to zero and stats_clr_i is ignored.
module pulp_clock_gate_ctrl #(
  parameter int N_DOMAINS   = 4,
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CNT_W-1:0]        cfg_idle_cycles_i,
  input  logic                    force_on_i,
  input  logic [N_DOMAINS-1:0]    busy_i,
  input  logic [N_DOMAINS-1:0]    wake_i,
  input  logic [N_DOMAINS-1:0]    sleep_ack_i,
  output logic [N_DOMAINS-1:0]    sleep_req_o,
  output logic [N_DOMAINS-1:0]    clk_en_o,
  output logic [N_DOMAINS-1:0]    ready_o,
  input  logic                    stats_clr_i,
  output logic [32*N_DOMAINS-1:0] gated_cnt_o
);

  localparam int WK_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WK_W-1:0] WAKE_LOAD = WK_W'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_e;

  // Timeout is shared by all domains; cfg of zero disables gating entirely
  logic w_cfg_en;
  assign w_cfg_en = (cfg_idle_cycles_i != '0);

  for (genvar g = 0; g < N_DOMAINS; g++) begin : g_dom
    state_e           r_state;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [WK_W-1:0]  r_wake_cnt;
    logic             r_clk_en;
    logic             r_ready;
    logic             r_sleep_req;
    logic             w_wake_evt;
    logic             w_abort;
    logic             w_timeout;

    assign w_wake_evt = wake_i[g] | force_on_i;
    assign w_abort    = busy_i[g] | w_wake_evt;
    // Compare against cfg-1 so the request rises right after the cfg-th idle cycle
    assign w_timeout  = w_cfg_en && (r_idle_cnt >= (cfg_idle_cycles_i - CNT_W'(1)));

    // Per-domain sleep FSM with registered outputs
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state     <= S_RUN;
        r_idle_cnt  <= '0;
        r_wake_cnt  <= '0;
        r_clk_en    <= 1'b1;
        r_ready     <= 1'b1;
        r_sleep_req <= 1'b0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_abort) begin
              r_idle_cnt <= '0;
            end else if (w_timeout) begin
              r_state     <= S_DRAIN;
              r_sleep_req <= 1'b1;
              r_idle_cnt  <= '0;
            end else if (r_idle_cnt != '1) begin
              r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
          end
          S_DRAIN: begin
            // Abort has priority over an acknowledge arriving in the same cycle
            if (w_abort) begin
              r_state     <= S_RUN;
              r_sleep_req <= 1'b0;
              r_idle_cnt  <= '0;
            end else if (sleep_ack_i[g]) begin
              r_state  <= S_GATED;
              r_clk_en <= 1'b0;
              r_ready  <= 1'b0;
            end
          end
          S_GATED: begin
            if (w_wake_evt) begin
              r_state    <= S_WAKE;
              r_clk_en   <= 1'b1;
              r_wake_cnt <= WAKE_LOAD;
            end
          end
          S_WAKE: begin
            // Settle period cannot be aborted
            if (r_wake_cnt == '0) begin
              r_state     <= S_RUN;
              r_ready     <= 1'b1;
              r_sleep_req <= 1'b0;
              r_idle_cnt  <= '0;
            end else begin
              r_wake_cnt <= r_wake_cnt - WK_W'(1);
            end
          end
          default: begin
            r_state     <= S_RUN;
            r_clk_en    <= 1'b1;
            r_ready     <= 1'b1;
            r_sleep_req <= 1'b0;
            r_idle_cnt  <= '0;
          end
        endcase
      end
    end

    assign clk_en_o[g]    = r_clk_en;
    assign ready_o[g]     = r_ready;
    assign sleep_req_o[g] = r_sleep_req;

`ifdef PULP_CG_CTRL_STATS_EN
    logic [31:0] r_gated_cnt;

    // Count cycles with the gate enable low; clear beats increment
    always_ff @(posedge clk_i) begin
      if (rst_i || stats_clr_i) begin
        r_gated_cnt <= '0;
      end else if (!r_clk_en && (r_gated_cnt != 32'hFFFF_FFFF)) begin
        r_gated_cnt <= r_gated_cnt + 32'd1;
      end
    end

    assign gated_cnt_o[32*g +: 32] = r_gated_cnt;
`endif
  end

`ifndef PULP_CG_CTRL_STATS_EN
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr_i;
  assign gated_cnt_o        = '0;
`endif

endmodule

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Testbench for pulp_clock_gate_ctrl: directed handshake scenarios followed by
// randomized traffic, checked against a behavioural per-domain model.
module tb_pulp_clock_gate_ctrl;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int WC = 2;

  localparam int P_RUN   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_GATED = 2;
  localparam int P_WAKE  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   cfg;
  logic            force_on;
  logic [N-1:0]    busy;
  logic [N-1:0]    wake;
  logic [N-1:0]    ack;
  logic [N-1:0]    sleep_req_o;
  logic [N-1:0]    clk_en_o;
  logic [N-1:0]    ready_o;
  logic            stats_clr;
  logic [32*N-1:0] gated_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: phase, consecutive idle cycles, settle cycles left, gated count
  int     m_phase [N];
  int     m_idle  [N];
  int     m_left  [N];
  longint m_cnt   [N];

  pulp_clock_gate_ctrl #(
    .N_DOMAINS  (N),
    .CNT_W      (CW),
    .WAKE_CYCLES(WC)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_idle_cycles_i(cfg),
    .force_on_i       (force_on),
    .busy_i           (busy),
    .wake_i           (wake),
    .sleep_ack_i      (ack),
    .sleep_req_o      (sleep_req_o),
    .clk_en_o         (clk_en_o),
    .ready_o          (ready_o),
    .stats_clr_i      (stats_clr),
    .gated_cnt_o      (gated_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    for (int d = 0; d < N; d++) begin
      if (rst) begin
        m_phase[d] = P_RUN;
        m_idle[d]  = 0;
        m_left[d]  = 0;
        m_cnt[d]   = 0;
      end else begin
`ifdef PULP_CG_CTRL_STATS_EN
        if (stats_clr) m_cnt[d] = 0;
        else if (m_phase[d] == P_GATED && m_cnt[d] < 64'hFFFF_FFFF) m_cnt[d]++;
`endif
        case (m_phase[d])
          P_RUN: begin
            if (busy[d] || wake[d] || force_on) m_idle[d] = 0;
            else begin
              m_idle[d]++;
              if (cfg != 0 && m_idle[d] >= int'(cfg)) begin
                m_phase[d] = P_DRAIN;
                m_idle[d]  = 0;
              end
            end
          end
          P_DRAIN: begin
            if (busy[d] || wake[d] || force_on) begin
              m_phase[d] = P_RUN;
              m_idle[d]  = 0;
            end else if (ack[d]) m_phase[d] = P_GATED;
          end
          P_GATED: begin
            if (wake[d] || force_on) begin
              m_phase[d] = P_WAKE;
              m_left[d]  = WC;
            end
          end
          default: begin
            m_left[d]--;
            if (m_left[d] == 0) begin
              m_phase[d] = P_RUN;
              m_idle[d]  = 0;
            end
          end
        endcase
      end
    end
  endtask

  task automatic compare_model();
    logic [N-1:0]    e_en, e_rdy, e_req;
    logic [32*N-1:0] e_cnt;
    for (int d = 0; d < N; d++) begin
      e_en[d]          = (m_phase[d] != P_GATED);
      e_rdy[d]         = (m_phase[d] == P_RUN) || (m_phase[d] == P_DRAIN);
      e_req[d]         = (m_phase[d] != P_RUN);
      e_cnt[32*d +: 32] = m_cnt[d][31:0];
    end
    chk("model_clk_en", clk_en_o, e_en);
    chk("model_ready", ready_o, e_rdy);
    chk("model_sleep_req", sleep_req_o, e_req);
    chk("model_gated_cnt", gated_cnt_o, e_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; cfg = 8'd4; force_on = 1'b0; busy = '1; wake = '0; ack = '0; stats_clr = 1'b0;
    for (int d = 0; d < N; d++) begin
      m_phase[d] = P_RUN; m_idle[d] = 0; m_left[d] = 0; m_cnt[d] = 0;
    end
    steps(2);
    chk("reset_clk_en", clk_en_o, 4'hF);
    chk("reset_ready", ready_o, 4'hF);
    chk("reset_sleep_req", sleep_req_o, 4'h0);
    chk("reset_gated_cnt", gated_cnt_o, 128'h0);
    rst = 1'b0;
    step();

    // Idle timeout on domain 0 only
    busy = 4'b1110;
    steps(3);
    chk("req0_before_timeout", sleep_req_o, 4'b0000);
    step();
    chk("req0_at_edge4", sleep_req_o, 4'b0001);
    chk("clk_en_in_drain", clk_en_o, 4'hF);

    // Abort in DRAIN beats a simultaneous acknowledge
    busy = 4'b1111; ack = 4'b0001;
    step();
    chk("abort_req0", sleep_req_o, 4'b0000);
    chk("abort_clk_en", clk_en_o, 4'hF);
    busy = 4'b1110; ack = 4'b0000;
    steps(3);
    chk("re_drain_early", sleep_req_o, 4'b0000);
    step();
    chk("re_drain_req0", sleep_req_o, 4'b0001);

    // Acknowledge, gate, then wake with settle delay
    ack = 4'b0001;
    step();
    chk("gated_clk_en", clk_en_o, 4'b1110);
    chk("gated_ready", ready_o, 4'b1110);
    ack = 4'b0000; busy = 4'b1111;
    steps(3);
    chk("gated_ignores_busy", clk_en_o, 4'b1110);
    wake = 4'b0001;
    step();
    wake = 4'b0000;
    chk("wake_clk_en", clk_en_o, 4'hF);
    chk("wake_ready_low", ready_o, 4'b1110);
    step();
    chk("wake_ready_still_low", ready_o, 4'b1110);
    step();
    chk("wake_ready_back", ready_o, 4'hF);
    chk("wake_req_cleared", sleep_req_o, 4'h0);

    // Gating disabled by a zero timeout
    cfg = 8'd0; busy = 4'b0000;
    steps(300);
    chk("cfg0_no_req", sleep_req_o, 4'h0);

    // Gate domains 1..3, then exercise stats and force_on
    cfg = 8'd4; busy = 4'b0001;
    steps(4);
    chk("drain_1to3", sleep_req_o, 4'b1110);
    ack = 4'b1110;
    step();
    ack = 4'b0000;
    chk("gated_1to3", clk_en_o, 4'b0001);
    steps(10);
`ifdef PULP_CG_CTRL_STATS_EN
    chk("stats_dom2_10", gated_cnt_o[95:64], 32'd10);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_clr", gated_cnt_o[95:64], 32'd0);
    step();
    chk("stats_resume", gated_cnt_o[95:64], 32'd1);
`else
    chk("stats_off_zero", gated_cnt_o, 128'h0);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
`endif
    force_on = 1'b1;
    step();
    force_on = 1'b0;
    chk("force_clk_en", clk_en_o, 4'hF);
    chk("force_ready_low", ready_o, 4'b0001);
    steps(2);
    chk("force_ready_all", ready_o, 4'hF);
    chk("force_req_all", sleep_req_o, 4'h0);

    // Reset while gated
    steps(4);
    ack = 4'b1110;
    step();
    ack = 4'b0000;
    chk("pre_rst_gated", clk_en_o, 4'b0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_gated_en", clk_en_o, 4'hF);
    chk("rst_gated_rdy", ready_o, 4'hF);
    chk("rst_gated_req", sleep_req_o, 4'h0);

    // Reset while waking
    steps(4);
    ack = 4'b1110;
    step();
    ack = 4'b0000;
    wake = 4'b1110;
    step();
    wake = 4'b0000;
    chk("pre_rst_wake", ready_o, 4'b0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_wake_rdy", ready_o, 4'hF);
    chk("rst_wake_req", sleep_req_o, 4'h0);
    chk("rst_wake_cnt", gated_cnt_o, 128'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) cfg = CW'($urandom_range(0, 6));
      for (int d = 0; d < N; d++) begin
        busy[d] = ($urandom_range(0, 5) == 0);
        wake[d] = ($urandom_range(0, 11) == 0);
        ack[d]  = ($urandom_range(0, 2) == 0);
      end
      force_on  = ($urandom_range(0, 59) == 0);
      stats_clr = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulp_clock_gate_ctrl.md
Name: pulp_clock_gate_ctrl

Overview:
- Idle-timeout sequencer for N independently gated clock domains.
- Each clk_en_o bit drives the en_i of one cell-level clock gate instance.
- Watches per-domain busy, runs a sleep request/acknowledge handshake with the domain, gates its clock, and restores it on wake with a fixed settle delay.
- Sits in the SoC control block beside the peripheral clock gates; runs on the ungated clock.

Parameters:
- N_DOMAINS, 4, number of gated domains controlled.
- CNT_W, 8, width of idle counter and of cfg_idle_cycles_i.
- WAKE_CYCLES, 2, cycles clk_en_o is high before ready_o reasserts on wake (≥1).

Ports:
- clk_i  in  1  free-running (ungated) clock.
- rst_i  in  1  synchronous reset, active-high.
- cfg_idle_cycles_i  in  CNT_W  consecutive idle cycles before sleep request; 0 = gating disabled.
- force_on_i  in  1  global override: wakes/holds all domains running.
- busy_i  in  N_DOMAINS  domain has outstanding work.
- wake_i  in  N_DOMAINS  external wake event (IRQ, bus access) per domain.
- sleep_ack_i  in  N_DOMAINS  domain has quiesced and accepts gating.
- sleep_req_o  out  N_DOMAINS  request domain to quiesce; held while gated.
- clk_en_o  out  N_DOMAINS  enable to domain clock gate.
- ready_o  out  N_DOMAINS  domain clock running and settled.
- stats_clr_i  in  1  clear gated-cycle counters (optional feature).
- gated_cnt_o  out  32*N_DOMAINS  per-domain gated-cycle counters, domain d at [32d+31:32d] (optional feature).

Behaviour:
- Reset: rst_i sampled high at a clk_i edge → every domain in RUN; clk_en_o = all 1, ready_o = all 1, sleep_req_o = 0, idle and wake counters 0, gated_cnt_o = 0.
- Reset mid-handshake or while gated: same values on the next edge; no handshake completion required.
- All outputs are registered. Domains are fully independent; a per-domain FSM runs four states.
- RUN: clk_en_o = 1, ready_o = 1, sleep_req_o = 0.
  - Idle cycle means busy_i = 0, wake_i = 0, force_on_i = 0.
  - idle_cnt clears to 0 on any non-idle cycle, increments on idle cycles, and saturates.
  - Go to DRAIN when the cycle is idle, cfg_idle_cycles_i ≠ 0, and idle_cnt ≥ cfg_idle_cycles_i − 1.
  - Result: sleep_req_o rises on the edge after the cfg-th consecutive idle cycle.
  - cfg changes take effect immediately, using the ≥ compare.
- DRAIN: sleep_req_o = 1, clk_en_o = 1, ready_o = 1.
  - busy_i, wake_i or force_on_i high → abort to RUN, sleep_req_o = 0, idle_cnt = 0.
  - Otherwise sleep_ack_i high → GATED.
  - Abort and ack in the same cycle: abort wins.
  - No timeout: DRAIN waits indefinitely.
- GATED: clk_en_o = 0, ready_o = 0, sleep_req_o = 1.
  - busy_i and sleep_ack_i are ignored.
  - wake_i or force_on_i high → WAKE, wake_cnt loaded with WAKE_CYCLES − 1.
- WAKE: clk_en_o = 1, ready_o = 0, sleep_req_o = 1.
  - wake_cnt decrements each cycle; at 0 → RUN (sleep_req_o = 0, ready_o = 1, idle_cnt = 0).
  - Latency from wake_i sampled high in GATED to ready_o high: WAKE_CYCLES + 1 edges.
  - WAKE cannot be aborted.
- force_on_i held high: domains leave DRAIN/GATED as above and stay in RUN.
- clk_en_o never toggles more than once per clk_i cycle; the clock gate cell handles glitch-free latching.

Optional Feature:
- Macro: PULP_CG_CTRL_STATS_EN.
- Defined:
  - Per-domain 32-bit counter increments every cycle that domain's clk_en_o register is 0, saturating at 0xFFFFFFFF.
  - stats_clr_i high → all counters 0 on the next edge; clear wins over increment.
  - Counters reset to 0.
- Undefined:
  - gated_cnt_o tied to 0; stats_clr_i ignored; no counter flops.
  - Ports remain present in both builds.

Test Plan:
- Reset, cfg = 4, busy[0] 1→0 at edge 0, ack tied 0 → sleep_req_o[0] high from edge 4; clk_en_o[0] stays 1; other domains unaffected.
- DRAIN abort: in DRAIN, assert busy[0] together with sleep_ack[0] for 1 cycle → RUN next edge, sleep_req_o[0] = 0, clk_en_o[0] never 0; sleep_req_o[0] again 4 idle cycles after busy drops.
- Full cycle with WAKE_CYCLES = 2:
  - ack[0] in DRAIN → clk_en_o[0] = 0, ready_o[0] = 0 next edge.
  - wake_i[0] pulse → clk_en_o[0] = 1 next edge, ready_o[0] and sleep_req_o[0] = 1/0 three edges after wake.
- cfg = 0 with busy low 300 cycles → sleep_req_o stays 0. Then force_on_i pulse while domains 1–3 are GATED → all reach RUN with identical timing.
- rst_i asserted in GATED and in WAKE → all outputs at reset values on the next edge.
- STATS_EN:
  - Gate domain 2 for 10 cycles → gated_cnt_o[2] = 10.
  - stats_clr_i while still gated → 0 next edge, then increments resume.
  - Preload near 0xFFFFFFFF via long gate → saturates.
